// File: rtl/tone_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tone_source_arbiter
// Purpose  : Shares one beeper voice between the matrix keyboard (mx), the
//            PS/2 keyboard (kb) and the song player (sg). Manual notes are
//            debounced before they may win; after the last manual release the
//            voice stays silent for a beat-counted interval before the song
//            gets it back. Priority is mx > kb > sg, gated by the func mode.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            i_func            - 00 manual, 01 song, 10 song+manual, 11 mute
//            i_beat            - one-clk pulse per 1/4 beat
//            i_med_*, i_low_*  - note codes per source (0 = none)
//            o_med, o_low      - registered note to the voice
//            o_grant           - registered one-hot {sg,kb,mx}
//            o_song_pause      - freeze request to the song player
//            o_hold_act        - high while the post-release silence runs
// Revision : 1.0 - initial release
// ============================================================================
module tone_source_arbiter #(
  parameter int STABLE_CYC = 16,
  parameter int HOLD_BEATS = 4,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_func,
  input  logic       i_beat,
  input  logic [3:0] i_med_mx,
  input  logic [3:0] i_low_mx,
  input  logic [3:0] i_med_kb,
  input  logic [3:0] i_low_kb,
  input  logic [3:0] i_med_sg,
  input  logic [3:0] i_low_sg,
  output logic [3:0] o_med,
  output logic [3:0] o_low,
  output logic [2:0] o_grant,
  output logic       o_song_pause,
  output logic       o_hold_act
);

  localparam logic [CNT_W-1:0] c_stable    = CNT_W'(STABLE_CYC);
  localparam int               c_hold_w    = $clog2(HOLD_BEATS + 2);
  localparam logic [c_hold_w-1:0] c_hold_init = c_hold_w'(HOLD_BEATS);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SONG = 2'd1,
    ST_MAN  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Manual sources: index 0 = mx, index 1 = kb.
  logic [1:0][7:0] w_code;
  logic [1:0]      w_req;
  logic [1:0]      w_act;

  assign w_code = {{i_med_kb, i_low_kb}, {i_med_mx, i_low_mx}};
  assign w_act  = {|w_code[1], |w_code[0]};

  // A manual code qualifies only after it has been nonzero and unchanged for
  // STABLE_CYC cycles; the request also falls the very cycle the code moves.
  generate
    for (genvar g = 0; g < 2; g++) begin : g_qual
      logic [7:0]       r_prev;
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_prev <= '0;
          r_cnt  <= '0;
        end else begin
          r_prev <= w_code[g];
          if ((w_code[g] == '0) || (w_code[g] != r_prev)) begin
            r_cnt <= '0;
          end else if (r_cnt != c_stable) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_req[g] = (r_cnt == c_stable) && (w_code[g] == r_prev) && w_act[g];
    end
  endgenerate

  logic w_req_sg;
  logic w_legal_man;
  logic w_legal_sg;

  assign w_req_sg    = |{i_med_sg, i_low_sg};
  assign w_legal_man = (i_func == 2'b00) || (i_func == 2'b10);
  assign w_legal_sg  = (i_func == 2'b01) || (i_func == 2'b10);

  state_t              r_state, w_state_nxt;
  logic                r_sel_kb, w_sel_kb_nxt;
  logic [c_hold_w-1:0] r_hold_cnt, w_hold_nxt;
  logic [7:0]          r_man_note;

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_kb_nxt = r_sel_kb;
    w_hold_nxt   = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_legal_man && (|w_req)) begin
          w_state_nxt  = ST_MAN;
          w_sel_kb_nxt = ~w_req[0];
        end else if (w_legal_sg && w_req_sg) begin
          w_state_nxt = ST_SONG;
        end
      end
      ST_SONG: begin
        if (!w_legal_sg) begin
          w_state_nxt = ST_IDLE;
        end else if (w_legal_man && (|w_req)) begin
          w_state_nxt  = ST_MAN;
          w_sel_kb_nxt = ~w_req[0];
        end else if (!w_req_sg) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MAN: begin
        if (!w_legal_man) begin
          // Leaving manual mode (01 or 11) abandons the silence interval.
          w_state_nxt = ST_IDLE;
        end else if (r_sel_kb && w_req[0]) begin
          w_sel_kb_nxt = 1'b0;
        end else if (!w_act[r_sel_kb]) begin
          if (w_req[~r_sel_kb]) begin
            w_sel_kb_nxt = ~r_sel_kb;
          end else if (HOLD_BEATS == 0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_HOLD;
            w_hold_nxt  = c_hold_init;
          end
        end
      end
      ST_HOLD: begin
        // A manual request beats a coincident final beat.
        if (!w_legal_man) begin
          w_state_nxt = ST_IDLE;
        end else if (|w_req) begin
          w_state_nxt  = ST_MAN;
          w_sel_kb_nxt = ~w_req[0];
        end else if (i_beat) begin
          if (r_hold_cnt == c_hold_last) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_hold_nxt = r_hold_cnt - 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sel_kb   <= 1'b0;
      r_hold_cnt <= '0;
      r_man_note <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel_kb   <= w_sel_kb_nxt;
      r_hold_cnt <= w_hold_nxt;
      // Only a qualified code is latched, so a re-qualifying source keeps
      // its previous note sounding.
      if ((w_state_nxt == ST_MAN) && w_req[w_sel_kb_nxt]) begin
        r_man_note <= w_code[w_sel_kb_nxt];
      end
    end
  end

  // Grant of the current state, masked when the mode no longer allows it.
  logic [2:0] w_grant;
  logic       w_pause;

  always_comb begin
    w_grant = 3'b000;
    case (r_state)
      ST_SONG: w_grant = w_legal_sg ? 3'b100 : 3'b000;
      ST_MAN:  w_grant = w_legal_man ? (r_sel_kb ? 3'b010 : 3'b001) : 3'b000;
      default: w_grant = 3'b000;
    endcase
  end

  assign w_pause = ((r_state == ST_MAN) || (r_state == ST_HOLD)) && (i_func == 2'b10);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_med        <= '0;
      o_low        <= '0;
      o_grant      <= '0;
      o_song_pause <= 1'b0;
      o_hold_act   <= 1'b0;
    end else begin
      o_grant      <= w_grant;
      o_song_pause <= w_pause;
      o_hold_act   <= (r_state == ST_HOLD);
      if (w_grant[2]) begin
        {o_med, o_low} <= {i_med_sg, i_low_sg};
      end else if (|w_grant[1:0]) begin
        {o_med, o_low} <= r_man_note;
      end else begin
        {o_med, o_low} <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tone_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tone_source_arbiter
// Purpose  : Self-checking bench for tone_source_arbiter. A behavioural model
//            tracks who owns the voice and how long each manual code has been
//            steady; every cycle the registered outputs are compared with it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tone_source_arbiter;

  localparam int STABLE = 16;
  localparam int HOLDB  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] func = 2'b00;
  logic       beat = 1'b0;
  logic [3:0] med_mx = '0, low_mx = '0, med_kb = '0, low_kb = '0;
  logic [3:0] med_sg = '0, low_sg = '0;
  logic [3:0] o_med, o_low;
  logic [2:0] o_grant;
  logic       o_song_pause, o_hold_act;

  always #5 clk = ~clk;

  tone_source_arbiter #(
    .STABLE_CYC(STABLE),
    .HOLD_BEATS(HOLDB),
    .CNT_W     (8)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_func      (func),
    .i_beat      (beat),
    .i_med_mx    (med_mx),
    .i_low_mx    (low_mx),
    .i_med_kb    (med_kb),
    .i_low_kb    (low_kb),
    .i_med_sg    (med_sg),
    .i_low_sg    (low_sg),
    .o_med       (o_med),
    .o_low       (o_low),
    .o_grant     (o_grant),
    .o_song_pause(o_song_pause),
    .o_hold_act  (o_hold_act)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 nobody, 1 mx, 2 kb, 3 song. Silence interval tracked separately.
  int         m_run [2];
  logic [7:0] m_last[2];
  int         m_owner;
  bit         m_holding;
  int         m_left;
  logic [7:0] m_note;
  logic [2:0] e_grant;
  logic [7:0] e_note;
  logic [1:0] e_flags;

  function automatic logic [7:0] code_of(input int i);
    return (i == 0) ? {med_mx, low_mx} : {med_kb, low_kb};
  endfunction

  // Steady for more than STABLE edges and unchanged right now.
  function automatic bit m_req(input int i);
    logic [7:0] c;
    c = code_of(i);
    return (c != 0) && (c == m_last[i]) && (m_run[i] >= STABLE + 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i]  = 0;
      m_last[i] = '0;
    end
    m_owner = 0; m_holding = 0; m_left = 0; m_note = '0;
    e_grant = '0; e_note = '0; e_flags = '0;
  endtask

  task automatic model_edge();
    bit lm, ls, rsg;
    bit r[2];
    logic [7:0] cur[2];
    int n_owner, n_left, me, other;
    bit n_hold;
    if (rst) begin
      model_reset();
    end else begin
      lm  = (func == 2'b00) || (func == 2'b10);
      ls  = (func == 2'b01) || (func == 2'b10);
      rsg = ({med_sg, low_sg} != 0);
      for (int i = 0; i < 2; i++) begin
        cur[i] = code_of(i);
        r[i]   = m_req(i);
      end
      // what the voice hears after this edge
      if (m_owner == 3 && ls) begin
        e_grant = 3'b100; e_note = {med_sg, low_sg};
      end else if ((m_owner == 1 || m_owner == 2) && lm) begin
        e_grant = (m_owner == 1) ? 3'b001 : 3'b010; e_note = m_note;
      end else begin
        e_grant = 3'b000; e_note = 8'h00;
      end
      e_flags = {(((m_owner == 1 || m_owner == 2) || m_holding) && func == 2'b10), m_holding};
      // who owns the voice next
      n_owner = m_owner; n_hold = m_holding; n_left = m_left;
      if (m_holding) begin
        if (!lm) n_hold = 0;
        else if (r[0]) begin n_hold = 0; n_owner = 1; end
        else if (r[1]) begin n_hold = 0; n_owner = 2; end
        else if (beat) begin
          if (m_left == 1) n_hold = 0;
          else n_left = m_left - 1;
        end
      end else if (m_owner == 0) begin
        if (lm && r[0]) n_owner = 1;
        else if (lm && r[1]) n_owner = 2;
        else if (ls && rsg) n_owner = 3;
      end else if (m_owner == 3) begin
        if (!ls) n_owner = 0;
        else if (lm && (r[0] || r[1])) n_owner = r[0] ? 1 : 2;
        else if (!rsg) n_owner = 0;
      end else begin
        me = m_owner - 1; other = 1 - me;
        if (!lm) n_owner = 0;
        else if (m_owner == 2 && r[0]) n_owner = 1;
        else if (cur[me] == 0) begin
          if (r[other]) n_owner = other + 1;
          else begin
            n_owner = 0;
            if (HOLDB > 0) begin n_hold = 1; n_left = HOLDB; end
          end
        end
      end
      if ((n_owner == 1 || n_owner == 2) && !n_hold && r[n_owner-1]) m_note = cur[n_owner-1];
      m_owner = n_owner; m_holding = n_hold; m_left = n_left;
      for (int i = 0; i < 2; i++) begin
        if (cur[i] != 0 && cur[i] == m_last[i]) m_run[i] = (m_run[i] < 1000) ? m_run[i] + 1 : 1000;
        else m_run[i] = (cur[i] != 0) ? 1 : 0;
        m_last[i] = cur[i];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("grant", 16'(o_grant), 16'(e_grant));
    check("note",  16'({o_med, o_low}), 16'(e_note));
    check("flags", 16'({o_song_pause, o_hold_act}), 16'(e_flags));
  endtask

  task automatic clear_inputs();
    {med_mx, low_mx, med_kb, low_kb, med_sg, low_sg} = '0;
    beat = 1'b0;
  endtask

  task automatic flush();
    clear_inputs();
    for (int i = 0; i < 30; i++) begin
      beat = (i % 2 == 0);
      tick();
    end
    beat = 1'b0;
  endtask

  // ---------------- random stimulus ----------------
  int mx_left = 0, kb_left = 0, sg_left = 0, fn_left = 0;

  function automatic logic [7:0] rnd_note();
    logic [3:0] v;
    v = 4'($urandom_range(1, 7));
    case ($urandom_range(0, 2))
      0:       return {v, 4'h0};
      1:       return {4'h0, v};
      default: return {v, 4'($urandom_range(1, 7))};
    endcase
  endfunction

  function automatic logic [7:0] pick_manual();
    return ($urandom_range(0, 9) < 4) ? 8'h00 : rnd_note();
  endfunction

  function automatic int pick_dur();
    return ($urandom_range(0, 99) < 35) ? int'($urandom_range(1, 10)) : int'($urandom_range(18, 70));
  endfunction

  task automatic rand_stim();
    int f;
    if (mx_left == 0) begin {med_mx, low_mx} = pick_manual(); mx_left = pick_dur(); end
    else mx_left--;
    if (kb_left == 0) begin {med_kb, low_kb} = pick_manual(); kb_left = pick_dur(); end
    else kb_left--;
    if (sg_left == 0) begin
      {med_sg, low_sg} = ($urandom_range(0, 3) == 0) ? 8'h00 : rnd_note();
      sg_left = $urandom_range(6, 30);
    end else sg_left--;
    beat = ($urandom_range(0, 3) == 0);
    if (fn_left == 0) begin
      f = $urandom_range(0, 9);
      func = (f < 5) ? 2'b10 : (f < 7) ? 2'b00 : (f < 9) ? 2'b01 : 2'b11;
      fn_left = $urandom_range(150, 400);
    end else fn_left--;
  endtask

  bit seen;
  bit hit;

  initial begin
    model_reset();
    // reset state
    repeat (3) tick();
    check("reset_grant", 16'(o_grant), 16'h0);
    rst = 1'b0;

    // async reset in the middle of a song
    func = 2'b01; med_sg = 4'd5;
    repeat (5) tick();
    check("song_grant", 16'(o_grant), 16'h4);
    rst = 1'b1;
    #1;
    check("async_rst_grant", 16'(o_grant), 16'h0);
    check("async_rst_note", 16'({o_med, o_low}), 16'h0);
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    check("song_after_rst", 16'({o_grant, o_med}), 16'({3'b100, 4'd5}));

    // manual preempt of the song, then silence, then the song again
    clear_inputs(); func = 2'b10; low_sg = 4'd3;
    repeat (4) tick();
    med_mx = 4'd2;
    repeat (20) tick();
    check("mx_preempt", 16'({o_grant, o_med, o_song_pause}), 16'({3'b001, 4'd2, 1'b1}));
    med_mx = 4'd0;
    tick();
    for (int k = 0; k < 4; k++) begin
      beat = 1'b1; tick(); beat = 1'b0;
      if (k == 1) check("hold_act", 16'({o_hold_act, o_grant}), 16'({1'b1, 3'b000}));
      repeat (3) tick();
    end
    check("song_resume", 16'({o_grant, o_low}), 16'({3'b100, 4'd3}));

    // final beat and a fresh manual request on the same cycle
    med_mx = 4'd2;
    repeat (20) tick();
    med_mx = 4'd0;
    tick();
    repeat (3) begin beat = 1'b1; tick(); beat = 1'b0; tick(); end
    low_mx = 4'd5; hit = 0; seen = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (m_req(0)) begin beat = 1'b1; hit = 1; end
      tick();
      beat = 1'b0;
      seen |= (o_grant == 3'b100);
    end
    check("hold_beat_align", 16'(hit), 16'h1);
    repeat (2) begin tick(); seen |= (o_grant == 3'b100); end
    check("hold_to_man", 16'({o_grant, o_low, o_hold_act}), 16'({3'b001, 4'd5, 1'b0}));
    check("no_song_cycle", 16'(seen), 16'h0);
    flush();

    // bouncing kb never qualifies
    func = 2'b00; seen = 0;
    for (int i = 0; i < 12; i++) begin
      med_kb = 4'd4; repeat (5) begin tick(); seen |= (o_grant == 3'b010); end
      med_kb = 4'd0; repeat (5) begin tick(); seen |= (o_grant == 3'b010); end
    end
    check("bounce_grant", 16'(seen), 16'h0);
    check("bounce_note", 16'(o_med), 16'h0);

    // kb granted, mx preempts, mx release hands back to kb without a hold
    med_kb = 4'd6;
    repeat (20) tick();
    check("kb_grant", 16'({o_grant, o_med}), 16'({3'b010, 4'd6}));
    med_mx = 4'd1;
    repeat (20) tick();
    check("mx_over_kb", 16'({o_grant, o_med}), 16'({3'b001, 4'd1}));
    med_mx = 4'd0;
    repeat (2) tick();
    check("back_to_kb", 16'({o_grant, o_med, o_hold_act}), 16'({3'b010, 4'd6, 1'b0}));

    // mute, then song-only
    med_sg = 4'd5;
    func = 2'b11;
    tick();
    check("mute", 16'({o_grant, o_med, o_low}), 16'h0);
    func = 2'b01;
    repeat (2) tick();
    check("song_only", 16'({o_grant, o_med, o_song_pause}), 16'({3'b100, 4'd5, 1'b0}));
    flush();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rand_stim();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tone_source_arbiter.md
Name: tone_source_arbiter

Overview:
- Shares one beeper voice between three note requesters: matrix keyboard (mx), PS/2 keyboard (kb) and song player (sg).
- Decides the winner by func mode and fixed priority (mx > kb > sg) and qualifies manual notes against bounce.
- After a manual release, holds silence for a beat-counted interval before handing the voice back to the song.
- Sits between the note sources and a beep_ma/beep_ch voice; one instance per voice.

Parameters:
STABLE_CYC, 16, consecutive clk cycles a manual note code must be stable and nonzero before it is qualified
HOLD_BEATS, 4, beat pulses of silence after the last manual release before the song resumes (0 = no hold)
CNT_W, 8, width of the stability counters (must hold STABLE_CYC)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous reset, active-high
func  in  2  mode: 00 manual only, 01 song only, 10 song with manual preempt, 11 mute
beat  in  1  one-clk pulse per 1/4 beat
med_mx, low_mx  in  4 each  matrix keyboard note codes (0 = none, 1-7 = do-ti)
med_kb, low_kb  in  4 each  PS/2 keyboard note codes
med_sg, low_sg  in  4 each  song player note codes
med_o, low_o  out  4 each  registered note to the voice
grant  out  3  one-hot {sg,kb,mx}; 000 = none
song_pause  out  1  tells the song player to freeze its position
hold_act  out  1  high while in HOLD

Behaviour:
- Reset (async, rst=1): state IDLE; med_o/low_o=0; grant=000; song_pause=0; hold_act=0; all counters 0.
- A source is "active" when its {med,low} is nonzero.
- Qualification (mx and kb, independently):
  - The counter clears when the source's {med,low} differs from its last-cycle value, or when it is 0.
  - Otherwise the counter increments, saturating at STABLE_CYC.
  - req_x=1 while the counter equals STABLE_CYC.
  - A change of note while granted re-qualifies; the previous note keeps sounding meanwhile.
  - The source drops immediately when it goes to 0.
- req_sg = sg active; no qualification.
- Mode legality:
  - 00: mx, kb only.
  - 01: sg only.
  - 10: all sources.
  - 11: nothing.
- States:
  - IDLE:
    - A legal manual req goes to MAN; mx wins if both are requesting.
    - Else, if sg is legal and req_sg, goes to SONG.
  - SONG: grant=sg.
    - A legal manual req goes to MAN the next cycle.
    - Loss of req_sg goes to IDLE.
  - MAN: grant=mx or kb.
    - mx qualifying while kb is granted switches the grant to mx the next cycle (preempt).
    - The granted source dropping with the other manual req present switches the grant to that source.
    - The granted source dropping with neither manual req present goes to HOLD with hold_cnt=HOLD_BEATS, or straight to the IDLE evaluation if HOLD_BEATS=0.
  - HOLD: grant=000; outputs 0; hold_act=1.
    - hold_cnt decrements on beat.
    - A legal manual req returns to MAN immediately; the counter is discarded.
    - A beat while hold_cnt==1 goes to IDLE; IDLE then resumes SONG next cycle if legal.
- Output timing:
  - med_o/low_o register the granted source's codes, giving one clk of latency from the state/grant decision.
  - Outputs are 0 when grant=000.
  - grant is registered and aligned with med_o/low_o.
- song_pause=1 in MAN and HOLD when func=10; 0 otherwise. Registered, aligned with grant.
- func change:
  - Re-evaluated every cycle.
  - If the current grant becomes illegal, go to IDLE the next cycle with outputs 0, then arbitrate normally.
  - func=11 forces IDLE and holds it.
  - Entering mode 01 from MAN or HOLD skips the hold.
- Simultaneous events:
  - In HOLD, manual req and the final beat arriving together: MAN wins.
  - mx and kb qualifying on the same cycle: mx wins.
- beat arriving outside HOLD is ignored.

Test Plan:
- Reset mid-SONG with med_sg=5: assert rst -> outputs 0, grant=000, asynchronously; release -> SONG is granted about 2 clk later.
- func=10, song playing low_sg=3; hold med_mx=2 for 16 clk -> grant=001, med_o=2, song_pause=1 one clk after qualification. Drop mx -> 4 beats of silence with hold_act=1, then grant=100 and low_o=3.
- Bounce: med_kb toggles 4↔0 every 5 clk (STABLE_CYC=16) -> grant never 010, med_o unchanged.
- kb granted med_kb=6; mx qualifies med_mx=1 -> grant switches to 001 and med_o=1 next clk. Drop mx -> grant=010, med_o=6, no HOLD.
- In HOLD with hold_cnt=1: beat and mx qualification on the same cycle -> MAN, grant=001, no SONG cycle.
- func 00 with kb granted, switch func to 11 -> IDLE, outputs 0 next clk. Set func=01 -> SONG if song active, song_pause=0.
